// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: fetch control and redirect, instruction memory port, decode handshake.
// master = fetch stage, slave = environment (memory, decode, branch unit).
interface instr_fetch_if;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    modport master (
        input  fetch_en, redirect_valid, redirect_pc, imem_data, id_ready,
        output imem_addr, if_valid, if_instr, if_pc
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_pc, imem_data, id_ready,
        input  imem_addr, if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: PC register driving a combinational imem, 2-entry fetch queue feeding decode.
// Latency: a word pushed at edge N is visible on if_* after edge N; redirect costs one empty cycle.
// Backpressure: id_ready low fills the queue, then pc holds. FETCH_PERF_EN adds push/stall counters.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    instr_fetch_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    logic [31:0] pc;
    logic [1:0]  count;
    logic        head;
    logic        tail;
    logic [31:0] q_instr [2];
    logic [31:0] q_pc    [2];
    logic        pop;
    logic        push;
    logic        unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    // With count==2 the tail aliases the head; that slot is only written when the head pops.
    assign tail = head ^ count[0];
    assign pop  = bus.if_valid & bus.id_ready;
    assign push = bus.fetch_en & ~bus.redirect_valid & ((count != QDEPTH[1:0]) | pop);

    assign bus.imem_addr = {2'b00, pc[31:2]};
    assign bus.if_valid  = (count != 2'd0);
    assign bus.if_instr  = q_instr[head];
    assign bus.if_pc     = q_pc[head];

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc    <= RESET_PC;
            count <= 2'd0;
            head  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                q_instr[i] <= 32'd0;
                q_pc[i]    <= 32'd0;
            end
        end else if (bus.redirect_valid) begin
            count <= 2'd0;
            pc    <= {bus.redirect_pc[31:2], 2'b00};
        end else begin
            if (push) begin
                q_instr[tail] <= bus.imem_data;
                q_pc[tail]    <= pc;
                pc            <= pc + 32'd4;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef FETCH_PERF_EN
    logic stall_cycle;
    assign stall_cycle = bus.fetch_en & ~bus.redirect_valid & ~push;

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (push)        perf_fetched <= perf_fetched + 32'd1;
            if (stall_cycle) perf_stall   <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic against a queue-based reference model.
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    instr_fetch_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    instr_fetch #(.RESET_PC(RESET_PC), .QDEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] waddr);
        return (waddr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign bus.imem_data = mem_word(bus.imem_addr);

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: byte PC, in-order queue of fetched words, perf counts.
    logic [31:0] m_pc;
    ent_t        m_q[$];
    logic        m_just_reset;
    logic [31:0] m_fetched;
    logic [31:0] m_stall;

    task automatic check_outputs();
        chk("imem_addr", bus.imem_addr, m_pc >> 2);
        chk("if_valid", {31'd0, bus.if_valid}, {31'd0, (m_q.size() != 0)});
        if (m_q.size() != 0) begin
            chk("if_instr", bus.if_instr, m_q[0].instr);
            chk("if_pc", bus.if_pc, m_q[0].pc);
        end else if (m_just_reset) begin
            chk("rst_instr", bus.if_instr, 32'd0);
            chk("rst_pc", bus.if_pc, 32'd0);
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_stall", perf_stall, m_stall);
`endif
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic cycle(input logic fe, input logic rv, input logic [31:0] rpc,
                         input logic rdy, input logic rst_n);
        bit pop, push;
        reset              = rst_n;
        bus.fetch_en       = fe;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.id_ready       = rdy;
        pop  = (m_q.size() != 0) && rdy;
        push = fe && !rv && ((m_q.size() < 2) || pop);
        if (!rst_n) begin
            m_pc = RESET_PC;
            m_q.delete();
            m_just_reset = 1'b1;
            m_fetched = 32'd0;
            m_stall   = 32'd0;
        end else begin
            m_just_reset = 1'b0;
            if (push) m_fetched = m_fetched + 32'd1;
            if (fe && !rv && !push) m_stall = m_stall + 32'd1;
            if (rv) begin
                m_q.delete();
                m_pc = rpc & 32'hFFFF_FFFC;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    m_q.push_back('{instr: mem_word(m_pc >> 2), pc: m_pc});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        m_pc = RESET_PC;
        m_just_reset = 1'b0;
        m_fetched = 32'd0;
        m_stall = 32'd0;

        // Reset, then streaming fetch with decode always ready.
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);

        // Decode stall: queue fills, pc holds, head stable; then drain in order.
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);

        // Redirect while full, with unaligned target.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000_0043, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);

        // PC wrap at the top of the address space.
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);

        // Reset beats redirect with a full queue.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000_1000, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);

        // Perf scenario: 5 fetches, 3 full stalls, 1 redirect cycle.
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        fe, rv, rdy, rst_n;
            logic [31:0] rpc;
            fe    = ($urandom_range(0, 7) != 0);
            rv    = ($urandom_range(0, 11) == 0);
            rdy   = ($urandom_range(0, 9) < 6);
            rst_n = ($urandom_range(0, 99) != 0);
            rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            cycle(fe, rv, rpc, rdy, rst_n);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
